// File: rtl/bus85_trace.sv
// 8085 bus-cycle tracer: rebuilds each machine cycle into {type, address, data} and queues it in a FWFT FIFO.
// Optional bus-idle watchdog is built only when BUS85_WDOG_EN is defined.
module bus85_trace #(
    parameter int unsigned DATASIZE   = 8,
    parameter int unsigned ADDRSIZE   = 16,
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned WDOG_MAX   = 4096
) (
    input  logic                               clk,
    input  logic                               rst_,
    input  logic [DATASIZE-1:0]                addrdata,
    input  logic [ADDRSIZE-DATASIZE-1:0]       addr,
    input  logic                               ale,
    input  logic                               rd_,
    input  logic                               wr_,
    input  logic                               iom_,
    input  logic                               s1,
    input  logic                               s0,
    input  logic                               inta_,
    input  logic                               trc_rd,
    output logic [3+ADDRSIZE+DATASIZE-1:0]     trc_data,
    output logic                               trc_empty,
    output logic                               trc_full,
    output logic [7:0]                         trc_ovf,
    output logic                               halted,
    output logic                               timeout
);
    localparam int unsigned HI_W  = ADDRSIZE - DATASIZE;
    localparam int unsigned REC_W = 3 + ADDRSIZE + DATASIZE;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PTR_W = DEPTH_LOG2 + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ALE  = 2'd1;
    localparam logic [1:0] ST_ADDR = 2'd2;
    localparam logic [1:0] ST_STRB = 2'd3;

    if (WDOG_MAX < 1) begin : g_bad_wdog
        $error("bus85_trace: WDOG_MAX must be at least 1");
    end

    // Registered copies of the bus pins; the FSM never looks at raw inputs
    logic [DATASIZE-1:0] ad_q;
    logic [HI_W-1:0]     ah_q;
    logic                ale_q, rdn_q, wrn_q, iomn_q, s1_q, s0_q, intan_q;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            ad_q    <= '0;
            ah_q    <= '0;
            ale_q   <= 1'b0;
            rdn_q   <= 1'b1;
            wrn_q   <= 1'b1;
            iomn_q  <= 1'b1;
            s1_q    <= 1'b0;
            s0_q    <= 1'b0;
            intan_q <= 1'b1;
        end else begin
            ad_q    <= addrdata;
            ah_q    <= addr;
            ale_q   <= ale;
            rdn_q   <= rd_;
            wrn_q   <= wr_;
            iomn_q  <= iom_;
            s1_q    <= s1;
            s0_q    <= s0;
            intan_q <= inta_;
        end
    end

    logic [1:0]          state_q, state_d;
    logic [ADDRSIZE-1:0] cyc_addr_q, cyc_addr_d;
    logic [3:0]          stat_q, stat_d;
    logic [DATASIZE-1:0] cyc_data_q, cyc_data_d;
    logic                inta_seen_q, inta_seen_d;
    logic                commit_c;
    logic                strobe_lo_c;

    assign strobe_lo_c = ~rdn_q | ~wrn_q | ~intan_q;

    // Address is captured on every sampled ALE-high cycle, whichever state the FSM is in
    always_comb begin
        state_d     = state_q;
        cyc_addr_d  = cyc_addr_q;
        stat_d      = stat_q;
        cyc_data_d  = cyc_data_q;
        inta_seen_d = inta_seen_q;
        commit_c    = 1'b0;
        if (ale_q) begin
            cyc_addr_d  = {ah_q, ad_q};
            stat_d      = {iomn_q, s1_q, s0_q, intan_q};
            inta_seen_d = 1'b0;
        end
        case (state_q)
            ST_IDLE: if (ale_q) state_d = ST_ALE;
            ST_ALE:  if (!ale_q) state_d = ST_ADDR;
            ST_ADDR: begin
                if (strobe_lo_c) begin
                    state_d     = ST_STRB;
                    cyc_data_d  = ad_q;
                    inta_seen_d = ~intan_q;
                end else if (ale_q) begin
                    state_d = ST_ALE;
                end
            end
            default: begin
                if (strobe_lo_c && ale_q) begin
                    state_d = ST_ALE;
                end else if (strobe_lo_c) begin
                    cyc_data_d  = ad_q;
                    inta_seen_d = inta_seen_q | ~intan_q;
                end else begin
                    commit_c = 1'b1;
                    state_d  = ale_q ? ST_ALE : ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q     <= ST_IDLE;
            cyc_addr_q  <= '0;
            stat_q      <= 4'hF;
            cyc_data_q  <= '0;
            inta_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_addr_q  <= cyc_addr_d;
            stat_q      <= stat_d;
            cyc_data_q  <= cyc_data_d;
            inta_seen_q <= inta_seen_d;
        end
    end

    logic [2:0]       type_c;
    logic [REC_W-1:0] rec_c;

    // stat_q = {iom_, s1, s0, inta_}
    always_comb begin
        type_c = 3'd7;
        if (inta_seen_q || !stat_q[0]) begin
            type_c = 3'd5;
        end else begin
            case (stat_q[3:1])
                3'b010:  type_c = 3'd0;
                3'b001:  type_c = 3'd1;
                3'b110:  type_c = 3'd2;
                3'b101:  type_c = 3'd3;
                3'b011:  type_c = 3'd4;
                default: type_c = 3'd7;
            endcase
        end
    end

    assign rec_c = {type_c, cyc_addr_q, cyc_data_q};

    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic             empty_q, empty_d, full_q, full_d;
    logic [7:0]       ovf_q, ovf_d;
    logic             halted_q, halted_d;
    logic             pop_c, push_c;
    logic [REC_W-1:0] mem_q [DEPTH];

    // A commit into a full FIFO still lands when the head is popped on the same edge
    always_comb begin
        pop_c    = trc_rd & ~empty_q;
        push_c   = commit_c & (~full_q | pop_c);
        wptr_d   = push_c ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d   = pop_c ? rptr_q + PTR_W'(1) : rptr_q;
        empty_d  = (wptr_d == rptr_d);
        full_d   = (wptr_d[PTR_W-1] != rptr_d[PTR_W-1]) &&
                   (wptr_d[PTR_W-2:0] == rptr_d[PTR_W-2:0]);
        ovf_d    = ovf_q;
        if (commit_c && !push_c && ovf_q != 8'hFF) ovf_d = ovf_q + 8'd1;
        halted_d = halted_q | (commit_c && type_c == 3'd4 && cyc_data_q == DATASIZE'(8'h76));
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ovf_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
            halted_q <= halted_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) mem_q[wptr_q[PTR_W-2:0]] <= rec_c;
    end

    assign trc_data  = mem_q[rptr_q[PTR_W-2:0]];
    assign trc_empty = empty_q;
    assign trc_full  = full_q;
    assign trc_ovf   = ovf_q;
    assign halted    = halted_q;

`ifdef BUS85_WDOG_EN
    localparam int unsigned WDOG_W = $clog2(WDOG_MAX + 1);

    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              timeout_q, timeout_d;

    // Idle-cycle counter, cleared by every commit and parked at WDOG_MAX
    always_comb begin
        wdog_d = wdog_q;
        if (commit_c)                          wdog_d = '0;
        else if (wdog_q != WDOG_W'(WDOG_MAX))  wdog_d = wdog_q + WDOG_W'(1);
        timeout_d = timeout_q | (wdog_d == WDOG_W'(WDOG_MAX));
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_bus85_trace.sv
// Directed bench for bus85_trace: per-feature tasks with inline hand-computed expectations.
module tb_bus85_trace;
    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic [7:0]  addrdata = 8'h00;
    logic [7:0]  addr = 8'h00;
    logic        ale = 1'b0, rd_ = 1'b1, wr_ = 1'b1, iom_ = 1'b1, s1 = 1'b0, s0 = 1'b0, inta_ = 1'b1;
    logic        trc_rd = 1'b0;
    logic [26:0] trc_data;
    logic        trc_empty, trc_full, halted, timeout;
    logic [7:0]  trc_ovf;

    int errors = 0;
    int checks = 0;

    bus85_trace #(.DATASIZE(8), .ADDRSIZE(16), .DEPTH_LOG2(4), .WDOG_MAX(8)) dut (
        .clk(clk), .rst_(rst_), .addrdata(addrdata), .addr(addr), .ale(ale),
        .rd_(rd_), .wr_(wr_), .iom_(iom_), .s1(s1), .s0(s0), .inta_(inta_),
        .trc_rd(trc_rd), .trc_data(trc_data), .trc_empty(trc_empty), .trc_full(trc_full),
        .trc_ovf(trc_ovf), .halted(halted), .timeout(timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Strobe: 0 = rd_, 1 = wr_, 2 = inta_
    task automatic bus_cycle(input logic iom, input logic s1v, input logic s0v, input logic [15:0] a,
                             input logic [7:0] d, input int strobe, input logic pop);
        ale = 1'b1; addr = a[15:8]; addrdata = a[7:0]; iom_ = iom; s1 = s1v; s0 = s0v;
        step();
        ale = 1'b0; addrdata = d;
        step();
        if (strobe == 0) rd_ = 1'b0; else if (strobe == 1) wr_ = 1'b0; else inta_ = 1'b0;
        step();
        rd_ = 1'b1; wr_ = 1'b1; inta_ = 1'b1;
        step();
        trc_rd = pop;
        step();
        trc_rd = 1'b0;
    endtask

    task automatic pop_check(input logic [26:0] exp, input string name);
        checks++;
        if (trc_data !== exp) begin
            errors++;
            $display("FAIL %s: trc_data got %h expected %h", name, trc_data, exp);
        end
        trc_rd = 1'b1;
        step();
        trc_rd = 1'b0;
    endtask

    task automatic check_bit(input logic got, input logic exp, input string name);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_ = 1'b0; ale = 1'b0; rd_ = 1'b1; wr_ = 1'b1; inta_ = 1'b1; trc_rd = 1'b0;
        step();
        step();
        rst_ = 1'b1;
    endtask

    task automatic test_reset();
        rst_ = 1'b0;
        step();
        check_bit(trc_empty, 1'b1, "reset_empty");
        check_bit(trc_full, 1'b0, "reset_full");
        checks++;
        if (trc_ovf !== 8'h00) begin errors++; $display("FAIL reset_ovf: got %h expected 00", trc_ovf); end
        check_bit(halted, 1'b0, "reset_halted");
        check_bit(timeout, 1'b0, "reset_timeout");
        do_reset();
    endtask

    task automatic test_mem_read();
        ale = 1'b1; addr = 8'h12; addrdata = 8'h34; iom_ = 1'b0; s1 = 1'b1; s0 = 1'b0;
        step();
        ale = 1'b0; addrdata = 8'hA5;
        step();
        rd_ = 1'b0;
        step();
        rd_ = 1'b1;
        step();
        check_bit(trc_empty, 1'b1, "read_empty_1clk");
        step();
        check_bit(trc_empty, 1'b0, "read_empty_2clk");
        pop_check({3'd0, 16'h1234, 8'hA5}, "read_record");
        check_bit(trc_empty, 1'b1, "read_popped_empty");
    endtask

    task automatic test_halt();
        ale = 1'b1; addr = 8'h00; addrdata = 8'h00; iom_ = 1'b0; s1 = 1'b1; s0 = 1'b1;
        step();
        ale = 1'b0; addrdata = 8'h76;
        step();
        rd_ = 1'b0;
        step();
        rd_ = 1'b1;
        step();
        check_bit(halted, 1'b0, "halt_before_commit");
        step();
        check_bit(halted, 1'b1, "halt_on_commit");
        check_bit(trc_empty, 1'b0, "halt_same_edge_record");
        pop_check({3'd4, 16'h0000, 8'h76}, "halt_record");
    endtask

    task automatic test_types();
        logic [2:0]  tiom [5] = '{3'b001, 3'b110, 3'b101, 3'b111, 3'b100};
        int          tstb [5] = '{1, 0, 1, 2, 0};
        logic [15:0] tadr [5] = '{16'h4000, 16'h2020, 16'h4141, 16'hABCD, 16'h0F0F};
        logic [7:0]  tdat [5] = '{8'h5A, 8'h3C, 8'hC3, 8'hFF, 8'h81};
        logic [2:0]  ttyp [5] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd7};
        for (int i = 0; i < 5; i++) begin
            bus_cycle(tiom[i][2], tiom[i][1], tiom[i][0], tadr[i], tdat[i], tstb[i], 1'b0);
            pop_check({ttyp[i], tadr[i], tdat[i]}, $sformatf("type_%0d", i));
        end
        check_bit(halted, 1'b1, "halt_sticky");
    endtask

    task automatic test_overflow();
        do_reset();
        check_bit(halted, 1'b0, "halt_cleared_by_reset");
        for (int i = 0; i < 17; i++) begin
            bus_cycle(1'b0, 1'b0, 1'b1, 16'h2000 + 16'(i), 8'h10 + 8'(i), 1, 1'b0);
            check_bit(trc_full, (i >= 15), $sformatf("fill_full_%0d", i));
        end
        checks++;
        if (trc_ovf !== 8'h01) begin errors++; $display("FAIL ovf_count: got %h expected 01", trc_ovf); end
        checks++;
        if (trc_data !== {3'd1, 16'h2000, 8'h10}) begin
            errors++;
            $display("FAIL ovf_head: got %h expected %h", trc_data, {3'd1, 16'h2000, 8'h10});
        end
    endtask

    task automatic test_back_to_back();
        bus_cycle(1'b0, 1'b1, 1'b0, 16'h3000, 8'hEE, 0, 1'b1);
        check_bit(trc_full, 1'b1, "b2b_still_full");
        checks++;
        if (trc_ovf !== 8'h01) begin errors++; $display("FAIL b2b_ovf: got %h expected 01", trc_ovf); end
        for (int i = 0; i < 15; i++)
            pop_check({3'd1, 16'h2001 + 16'(i), 8'h11 + 8'(i)}, $sformatf("drain_%0d", i));
        check_bit(trc_empty, 1'b0, "drain_last_present");
        pop_check({3'd0, 16'h3000, 8'hEE}, "drain_last");
        check_bit(trc_empty, 1'b1, "drain_empty");
        check_bit(trc_full, 1'b0, "drain_not_full");
    endtask

    task automatic test_abort();
        ale = 1'b1; addr = 8'h55; addrdata = 8'h01; iom_ = 1'b0; s1 = 1'b1; s0 = 1'b0;
        step();
        ale = 1'b0;
        repeat (3) step();
        ale = 1'b1; addr = 8'h66; addrdata = 8'h02;
        step();
        ale = 1'b0;
        repeat (4) step();
        check_bit(trc_empty, 1'b1, "strobeless_no_record");
        bus_cycle(1'b0, 1'b1, 1'b0, 16'h5678, 8'h99, 0, 1'b0);
        checks++;
        if (trc_data !== {3'd0, 16'h5678, 8'h99}) begin
            errors++;
            $display("FAIL recover_record: got %h expected %h", trc_data, {3'd0, 16'h5678, 8'h99});
        end
        ale = 1'b1; addr = 8'h77; addrdata = 8'h03;
        step();
        ale = 1'b0; addrdata = 8'h44;
        step();
        rd_ = 1'b0;
        repeat (2) step();
        rst_ = 1'b0;
        #1;
        check_bit(trc_empty, 1'b1, "strb_reset_empty");
        check_bit(trc_full, 1'b0, "strb_reset_full");
        check_bit(halted, 1'b0, "strb_reset_halted");
        rd_ = 1'b1;
        step();
        rst_ = 1'b1;
        repeat (4) step();
        check_bit(trc_empty, 1'b1, "strb_reset_no_record");
    endtask

    task automatic test_timeout();
        rst_ = 1'b0;
        step();
        rst_ = 1'b1;
`ifdef BUS85_WDOG_EN
        repeat (7) step();
        check_bit(timeout, 1'b0, "timeout_before_8");
        step();
        check_bit(timeout, 1'b1, "timeout_at_8");
        repeat (3) step();
        check_bit(timeout, 1'b1, "timeout_sticky");
`else
        repeat (20) step();
        check_bit(timeout, 1'b0, "timeout_disabled");
`endif
    endtask

    initial begin
        test_reset();
        test_mem_read();
        test_halt();
        test_types();
        test_overflow();
        test_back_to_back();
        test_abort();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
